// File: rtl/sqrt_arb.sv
// rtl/sqrt_arb.sv - round-robin arbiter sharing one square-root core among four requesters
// Optional feature: define SQRT_ARB_TIMEOUT_EN to add a watchdog on the WAIT state.
module sqrt_arb #(
  parameter int W   = 17,
  parameter int TMO = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     req_valid,
  input  logic [4*W-1:0] req_data,
  output logic [3:0]     req_ready,
  output logic [W-1:0]   core_x,
  output logic           core_start,
  input  logic           core_done,
  input  logic [W-1:0]   core_f,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [1:0]     rsp_id,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_err,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e       state_q;
  logic [1:0]   last_q;
  logic [1:0]   id_q;
  logic [W-1:0] op_q;
  logic [W-1:0] data_q;
  logic         start_q;
  logic         valid_q;
  logic         err_q;

  logic         grant_vld;
  logic [1:0]   grant_idx;
  logic [1:0]   cand;
  logic [W-1:0] grant_op;

  // Round-robin search: first requesting index at or above last+1, wrapping at 4
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    grant_op = req_data[int'(grant_idx)*W +: W];
  end

  // The accept strobe is combinational in the IDLE grant cycle and held low during reset
  assign req_ready = (reset && state_q == IDLE && grant_vld) ? (4'b0001 << grant_idx) : 4'b0000;

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

  logic [CW-1:0] tmo_cnt_q;
  logic          tmo_hit;

  // Counts completed WAIT cycles; the last allowed cycle is TMO-1
  assign tmo_hit = (tmo_cnt_q == CW'(TMO - 1));

  // Watchdog counter: cleared while issuing, so it starts at zero on entry to WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      tmo_cnt_q <= '0;
    end else if (state_q == WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TMO > 0);
`endif

  // Control FSM with registered outputs; core_done is only honoured in WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      id_q    <= 2'd0;
      op_q    <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            last_q <= grant_idx;
            id_q   <= grant_idx;
            op_q   <= grant_op;
            if (grant_op[W-1]) begin
              data_q  <= '0;
              err_q   <= 1'b1;
              valid_q <= 1'b1;
              state_q <= RESP;
            end else begin
              start_q <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          start_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            data_q  <= core_f;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= RESP;
          end
`ifdef SQRT_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            data_q  <= '0;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= RESP;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_x     = op_q;
  assign core_start = start_q;
  assign rsp_valid  = valid_q;
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != IDLE);

endmodule
